// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous PWM input in clock cycles,
// flagging inputs that stay high or low long enough to saturate the edge counter.
module pwm_capture #(
  parameter int CNT_W       = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_pwm_in,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic             o_meas_valid,
  output logic             o_stuck_high,
  output logic             o_stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_ARM, ST_HIGH, ST_LOW} state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pwm_d;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_run_cnt;
  logic [CNT_W-1:0]       r_hi_tmp;
  logic [CNT_W-1:0]       r_high_cnt;
  logic [CNT_W-1:0]       r_period_cnt;
  logic                   r_meas_valid;
  logic                   r_stuck_high;
  logic                   r_stuck_low;

  logic                   w_pwm_s;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_sat;
  logic [CNT_W-1:0]       w_run_inc;
  logic [CNT_W:0]         w_period_sum;
  logic [CNT_W-1:0]       w_period;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_run_nxt;
  logic [CNT_W-1:0]       w_hi_tmp_nxt;
  logic [CNT_W-1:0]       w_high_nxt;
  logic [CNT_W-1:0]       w_period_nxt;
  logic                   w_meas_nxt;
  logic                   w_sh_nxt;
  logic                   w_sl_nxt;

  assign w_pwm_s   = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_pwm_s & ~r_pwm_d;
  assign w_fall    = ~w_pwm_s & r_pwm_d;
  assign w_sat     = (r_run_cnt == CNT_MAX);
  assign w_run_inc = w_sat ? CNT_MAX : r_run_cnt + CNT_W'(1);

  // run_cnt restarts at the fall, so the period is high time plus low time, clamped
  assign w_period_sum = {1'b0, r_hi_tmp} + {1'b0, r_run_cnt};
  assign w_period     = w_period_sum[CNT_W] ? CNT_MAX : w_period_sum[CNT_W-1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = w_run_inc;
    w_hi_tmp_nxt = r_hi_tmp;
    w_high_nxt   = r_high_cnt;
    w_period_nxt = r_period_cnt;
    w_meas_nxt   = 1'b0;
    w_sh_nxt     = r_stuck_high & ~w_fall;
    w_sl_nxt     = r_stuck_low & ~w_rise;
    if (!i_en) begin
      w_state_nxt = ST_ARM;
      w_run_nxt   = '0;
      w_sh_nxt    = 1'b0;
      w_sl_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_ARM: begin
          // While armed and high (e.g. after stuck-high) only a low level may time out
          if (w_rise) begin
            w_state_nxt = ST_HIGH;
            w_run_nxt   = CNT_W'(1);
          end else if (w_pwm_s) begin
            w_run_nxt = '0;
          end else if (w_sat) begin
            w_sl_nxt = 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_fall) begin
            w_hi_tmp_nxt = r_run_cnt;
            w_run_nxt    = CNT_W'(1);
            w_state_nxt  = ST_LOW;
          end else if (w_sat) begin
            w_sh_nxt    = 1'b1;
            w_run_nxt   = '0;
            w_state_nxt = ST_ARM;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_high_nxt   = r_hi_tmp;
            w_period_nxt = w_period;
            w_meas_nxt   = 1'b1;
            w_run_nxt    = CNT_W'(1);
            w_state_nxt  = ST_HIGH;
          end else if (w_sat) begin
            w_sl_nxt    = 1'b1;
            w_state_nxt = ST_ARM;
          end
        end
        default: begin
          w_state_nxt = ST_ARM;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync       <= '0;
      r_pwm_d      <= 1'b0;
      r_state      <= ST_ARM;
      r_run_cnt    <= '0;
      r_hi_tmp     <= '0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_meas_valid <= 1'b0;
      r_stuck_high <= 1'b0;
      r_stuck_low  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
      r_pwm_d      <= w_pwm_s;
      r_state      <= w_state_nxt;
      r_run_cnt    <= w_run_nxt;
      r_hi_tmp     <= w_hi_tmp_nxt;
      r_high_cnt   <= w_high_nxt;
      r_period_cnt <= w_period_nxt;
      r_meas_valid <= w_meas_nxt;
      r_stuck_high <= w_sh_nxt;
      r_stuck_low  <= w_sl_nxt;
    end
  end

  assign o_high_cnt   = r_high_cnt;
  assign o_period_cnt = r_period_cnt;
  assign o_meas_valid = r_meas_valid;
  assign o_stuck_high = r_stuck_high;
  assign o_stuck_low  = r_stuck_low;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM shapes with known high/low times and checks reported counts and flags.
module tb_pwm_capture;
  localparam int CNT_W = 13;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             en    = 1'b0;
  logic             pwm   = 1'b0;
  logic [CNT_W-1:0] o_high_cnt;
  logic [CNT_W-1:0] o_period_cnt;
  logic             o_meas_valid;
  logic             o_stuck_high;
  logic             o_stuck_low;

  pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_pwm_in     (pwm),
    .o_high_cnt   (o_high_cnt),
    .o_period_cnt (o_period_cnt),
    .o_meas_valid (o_meas_valid),
    .o_stuck_high (o_stuck_high),
    .o_stuck_low  (o_stuck_low)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass   = 0;
  int n_checks = 0;
  int pulses   = 0;
  int viol     = 0;
  int pulse_cyc[$];
  logic             prev_valid = 1'b0;
  logic             prev_rst   = 1'b0;
  logic [CNT_W-1:0] prev_h     = '0;
  logic [CNT_W-1:0] prev_p     = '0;

  // Pulse log plus two invariants: one-cycle pulses, outputs change only with a pulse
  always @(negedge clk) begin
    if (o_meas_valid) begin
      pulses = pulses + 1;
      pulse_cyc.push_back(cyc);
    end
    if (rst_n && prev_rst && !o_meas_valid &&
        (o_high_cnt !== prev_h || o_period_cnt !== prev_p)) viol = viol + 1;
    if (prev_valid && o_meas_valid) viol = viol + 1;
    prev_valid = o_meas_valid;
    prev_rst   = rst_n;
    prev_h     = o_high_cnt;
    prev_p     = o_period_cnt;
  end

  int last_rise = 0;
  int base      = 0;
  int qb        = 0;
  int rise2     = 0;
  int r_cyc     = 0;
  int hs[3]     = '{1, 500, 999};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pwm_wave(input int h, input int l);
    pwm       = 1'b1;
    last_rise = cyc;
    step(h);
    pwm = 1'b0;
    step(l);
  endtask

  initial begin
    // reset state
    rst_n = 1'b0; en = 1'b1; pwm = 1'b0;
    step(3);
    check("rst_high_cnt", 32'(o_high_cnt), 0);
    check("rst_period_cnt", 32'(o_period_cnt), 0);
    check("rst_meas_valid", 32'(o_meas_valid), 0);
    check("rst_stuck_high", 32'(o_stuck_high), 0);
    check("rst_stuck_low", 32'(o_stuck_low), 0);
    rst_n = 1'b1;
    step(5);

    // 50/50 repeated four times: three pulses, 100 cycles apart, first 3 cycles after rise 2
    base = pulses;
    qb   = pulse_cyc.size();
    for (int i = 0; i < 4; i++) begin
      pwm_wave(50, 50);
      if (i == 1) rise2 = last_rise;
    end
    check("p4_pulse_count", 32'(pulses - base), 3);
    if (pulse_cyc.size() >= qb + 3) begin
      check("p4_first_latency", 32'(pulse_cyc[qb]), 32'(rise2 + 3));
      check("p4_spacing_1", 32'(pulse_cyc[qb+1] - pulse_cyc[qb]), 100);
      check("p4_spacing_2", 32'(pulse_cyc[qb+2] - pulse_cyc[qb+1]), 100);
    end else begin
      check("p4_pulse_log_size", 32'(pulse_cyc.size() - qb), 3);
    end
    check("p4_high_cnt", 32'(o_high_cnt), 50);
    check("p4_period_cnt", 32'(o_period_cnt), 100);

    // duty sweep at period 1000
    for (int k = 0; k < 3; k++) begin
      base = pulses;
      pwm_wave(hs[k], 1000 - hs[k]);
      pwm_wave(hs[k], 1000 - hs[k]);
      check("sweep_pulses", 32'(pulses - base), 2);
      check("sweep_high_cnt", 32'(o_high_cnt), 32'(hs[k]));
      check("sweep_period_cnt", 32'(o_period_cnt), 1000);
      check("sweep_stuck_high", 32'(o_stuck_high), 0);
      check("sweep_stuck_low", 32'(o_stuck_low), 0);
    end

    // held high: flag one cycle after run_cnt reaches 8191
    base  = pulses;
    pwm   = 1'b1;
    r_cyc = cyc;
    step(8193);
    check("sh_before_threshold", 32'(o_stuck_high), 0);
    step(1);
    check("sh_at_threshold", 32'(o_stuck_high), 1);
    step(9000 - 8194);
    check("sh_still_set", 32'(o_stuck_high), 1);
    check("sh_pulses_only_initial", 32'(pulses - base), 1);
    pwm = 1'b0;
    step(5);
    check("sh_cleared_by_fall", 32'(o_stuck_high), 0);
    base = pulses;
    step(25);
    pwm_wave(20, 30);
    pwm = 1'b1;
    step(5);
    check("sh_recover_pulses", 32'(pulses - base), 1);
    check("sh_recover_high", 32'(o_high_cnt), 20);
    check("sh_recover_period", 32'(o_period_cnt), 50);
    check("sh_recover_no_low_flag", 32'(o_stuck_low), 0);

    // held low from reset
    rst_n = 1'b0; pwm = 1'b0;
    step(2);
    rst_n = 1'b1;
    base  = pulses;
    step(9000);
    check("sl_set", 32'(o_stuck_low), 1);
    check("sl_no_pulses", 32'(pulses - base), 0);
    pwm = 1'b1;
    step(5);
    check("sl_cleared_by_rise", 32'(o_stuck_low), 0);
    check("sl_no_pulse_first_rise", 32'(pulses - base), 0);
    step(35);
    pwm = 1'b0;
    step(60);
    pwm = 1'b1;
    step(5);
    check("sl_pulse_second_rise", 32'(pulses - base), 1);
    check("sl_high_cnt", 32'(o_high_cnt), 40);
    check("sl_period_cnt", 32'(o_period_cnt), 100);

    // async reset mid-HIGH
    step(45);
    pwm = 1'b0;
    step(50);
    pwm = 1'b1;
    step(10);
    check("ar_pre_high", 32'(o_high_cnt), 50);
    check("ar_pre_period", 32'(o_period_cnt), 100);
    #3 rst_n = 1'b0;
    #1;
    check("ar_high_cleared", 32'(o_high_cnt), 0);
    check("ar_period_cleared", 32'(o_period_cnt), 0);
    pwm = 1'b0;
    step(2);
    rst_n = 1'b1;
    base  = pulses;
    step(20);
    pwm_wave(50, 50);
    check("ar_no_pulse_one_rise", 32'(pulses - base), 0);
    pwm = 1'b1;
    step(5);
    check("ar_pulse_two_rises", 32'(pulses - base), 1);
    check("ar_resume_high", 32'(o_high_cnt), 50);
    check("ar_resume_period", 32'(o_period_cnt), 100);

    // enable low for 300 cycles
    step(45);
    pwm = 1'b0;
    step(50);
    en   = 1'b0;
    base = pulses;
    for (int i = 0; i < 3; i++) pwm_wave(50, 50);
    check("en_off_no_pulses", 32'(pulses - base), 0);
    check("en_off_high_hold", 32'(o_high_cnt), 50);
    check("en_off_period_hold", 32'(o_period_cnt), 100);
    en = 1'b1;
    pwm_wave(30, 70);
    check("en_on_no_pulse_one_rise", 32'(pulses - base), 0);
    pwm = 1'b1;
    step(5);
    check("en_on_pulse_two_rises", 32'(pulses - base), 1);
    check("en_on_high", 32'(o_high_cnt), 30);
    check("en_on_period", 32'(o_period_cnt), 100);

    check("output_invariants", 32'(viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the PWM waveform produced by the PWM generator stage and reports its high time and period in `clk` cycles. It is the consumer directly downstream of the generator's `pwm` output, used for self-check on the board and in simulation. The input is treated as asynchronous and synchronized internally. Each complete rise-to-rise period produces one measurement; stuck-high and stuck-low inputs are flagged.

## Interface
- `CNT_W`, 13, width of measurement counters (matches the generator's 13-bit counter).
- `SYNC_STAGES`, 2, synchronizer flops on `pwm_in` (min 2).
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  capture enable; low forces re-arm.
- `pwm_in`  in  1  PWM waveform from the generator; asynchronous to `clk`.
- `high_cnt`  out  CNT_W  last measured high time, in cycles.
- `period_cnt`  out  CNT_W  last measured rise-to-rise period, in cycles.
- `meas_valid`  out  1  one-cycle pulse when `high_cnt`/`period_cnt` update.
- `stuck_high`  out  1  input held high for 2^CNT_W-1 cycles.
- `stuck_low`  out  1  input held low for 2^CNT_W-1 cycles (incl. since arm).

## Operation
- `pwm_in` → SYNC_STAGES flops → `pwm_s`. One extra flop `pwm_d` holds the previous value. rise = `pwm_s & ~pwm_d`; fall = `~pwm_s & pwm_d`.
- `run_cnt` (CNT_W bits) counts the cycles since the last accepted edge and saturates at 2^CNT_W-1.
- FSM states:
  - ARM: wait for the first rise. On rise: `run_cnt`=1, go to HIGH. Falls are ignored.
  - HIGH: on fall, latch `hi_tmp` = cycles high and go to LOW.
  - LOW: on rise, `high_cnt` ← `hi_tmp`, `period_cnt` ← cycles since previous rise, `meas_valid` pulses. Restart the count and go to HIGH.
- Sample values: a synchronized waveform with H cycles high and L cycles low reports `high_cnt`=H and `period_cnt`=H+L.
- Saturation in HIGH: set `stuck_high`, go to ARM, no `meas_valid`.
- Saturation in LOW or ARM: set `stuck_low`, stay in or go to ARM.
- Stuck flags are sticky until the next edge of the opposite sense, which clears them. A flag is also cleared when `en`=0.
- After a stuck condition, one full clean rise→fall→rise is required before the next `meas_valid`.
- `en`=0: FSM to ARM, `run_cnt`=0, flags cleared. `high_cnt`/`period_cnt` hold their last values. The synchronizer keeps running.
- `high_cnt`/`period_cnt` change only in the cycle in which `meas_valid`=1.

## Timing
- Reset values: `high_cnt`=0, `period_cnt`=0, `meas_valid`=0, `stuck_high`=0, `stuck_low`=0. FSM in ARM, synchronizer flops 0.
- Latency: if `pwm_in` is first sampled high at clk edge N, rise is detected in cycle N+SYNC_STAGES. `meas_valid` is registered and asserts in cycle N+SYNC_STAGES+1.
- Minimum measurable waveform: H=1, L=1 (period 2). Input pulses shorter than one cycle may be missed and are not an error.
- A rise and saturation in the same cycle: the rise wins. Count restarts and no flag is set.
- Saturation threshold: `run_cnt` reaching 2^CNT_W-1 (8191 for CNT_W=13). Flag asserts the following cycle.
- Async reset mid-period: all state cleared immediately. The first measurement after reset needs two rises.
- `en` deasserted in the same cycle as a would-be `meas_valid`: `en` wins, no pulse, outputs unchanged.

## Test plan
- Reset, then `pwm_in` with H=50, L=50, repeated 4×: first `meas_valid` after the second rise, with `high_cnt`=50 and `period_cnt`=100. Exactly 3 pulses for 4 rises, each 100 cycles apart.
- Duty sweep at period 1000, H=1 / 500 / 999: `high_cnt` matches each H, `period_cnt`=1000, no stuck flags.
- `pwm_in` held high for 9000 cycles after a rise: `stuck_high`=1 from cycle 8191 after the rise. No `meas_valid`. The flag clears on the next fall, and the following clean H=20, L=30 period reports 20/50.
- `pwm_in` held low from reset for 9000 cycles: `stuck_low`=1. The next rise clears it, and the first `meas_valid` comes after the second rise.
- Async `rst_n` pulse mid-HIGH while outputs hold 50/100: outputs go to 0 immediately. Measurement resumes correctly after two rises.
- `en`=0 for 300 cycles during a 100-cycle PWM: no `meas_valid`, outputs hold 50/100. After `en`=1, the first new pulse follows the second rise.
